// File: rtl/multi_tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Holds the default counter width, default divisor, channel limit and the
// per-channel state layout (shown at the default counter width).
package multi_tick_gen_pkg;

  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_DIV   = 5000000;
  localparam int unsigned MAX_CH    = 16;

  // One channel's architectural state at the default counter width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_CNT_W-1:0] active_div;
    logic [DEF_CNT_W-1:0] shadow_div;
    logic                 pending;
  } ch_state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divides the enabled clock by active_div and emits a
// registered one-cycle tick each period. New divisors are staged in a shadow
// register and only take effect at a period boundary, at sync_clr, or while
// the channel is disabled.
// Optional square-wave output: define MULTI_TICK_GEN_SQUARE_EN.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   en           - count enable
//   sync_clr     - restart counter, apply pending divisor
//   wr_hit       - divisor write addressed to this channel
//   wr_div       - divisor value for the write
//   tick         - registered one-cycle pulse per period
//   div_pending  - a staged divisor is waiting to be applied
//   sq_out       - registered square wave (0 when feature is not built)
module tick_channel
  import multi_tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             div_pending,
  output logic             sq_out
);

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] shadow_div;
    logic             pending;
  } state_t;

  state_t           st;
  state_t           st_nxt;
  logic             tick_nxt;
  logic             term;
  logic             pend_eff;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] shadow_eff;

  // Next-state: terminal detect, divisor staging and application.
  always_comb begin
    // Divisors 0 and 1 both mean "terminal every cycle".
    last       = (st.active_div <= CNT_W'(1)) ? '0 : st.active_div - CNT_W'(1);
    // >= rather than == so a divisor shrunk while disabled cannot strand the
    // held count above the new terminal value.
    term       = en && (st.count >= last);
    // A same-cycle write is visible to this cycle's application point.
    pend_eff   = st.pending | wr_hit;
    shadow_eff = wr_hit ? wr_div : st.shadow_div;

    st_nxt            = st;
    st_nxt.shadow_div = shadow_eff;
    st_nxt.pending    = pend_eff;
    tick_nxt          = 1'b0;

    if (sync_clr) begin
      st_nxt.count = '0;
      if (pend_eff) begin
        st_nxt.active_div = shadow_eff;
        st_nxt.pending    = 1'b0;
      end
    end else if (en) begin
      if (term) begin
        st_nxt.count = '0;
        tick_nxt     = 1'b1;
        if (pend_eff) begin
          st_nxt.active_div = shadow_eff;
          st_nxt.pending    = 1'b0;
        end
      end else begin
        st_nxt.count = st.count + CNT_W'(1);
      end
    end else if (st.pending) begin
      // Disabled channel: a divisor staged on an earlier cycle applies now.
      st_nxt.active_div = shadow_eff;
      st_nxt.pending    = 1'b0;
    end
  end

  // State and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st.count      <= '0;
      st.active_div <= CNT_W'(DEFAULT_DIV);
      st.shadow_div <= CNT_W'(DEFAULT_DIV);
      st.pending    <= 1'b0;
      tick          <= 1'b0;
    end else begin
      st   <= st_nxt;
      tick <= tick_nxt;
    end
  end

  assign div_pending = st.pending;

`ifdef MULTI_TICK_GEN_SQUARE_EN
  logic sq_q;

  // Toggle on the same edge that raises tick: period is 2*active_div.
  always_ff @(posedge clk) begin
    if (reset || sync_clr) begin
      sq_q <= 1'b0;
    end else if (term) begin
      sq_q <= ~sq_q;
    end
  end

  assign sq_out = sq_q;
`else
  assign sq_out = 1'b0;
`endif

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator. NUM_CH independent channels,
// each dividing clk by its own runtime-writable divisor, with a shared
// sync_clr for phase alignment.
// Optional square-wave outputs: define MULTI_TICK_GEN_SQUARE_EN.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   ch_en        - per-channel count enable
//   sync_clr     - restart all channels, apply pending divisors
//   wr_en        - divisor write strobe
//   wr_ch        - channel index for the write (out-of-range ignored)
//   wr_div       - divisor value
//   tick         - per-channel registered one-cycle pulse
//   div_pending  - per-channel staged-divisor flag
//   sq_out       - per-channel square wave (0 when feature is not built)
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned CNT_W       = DEF_CNT_W,
  parameter  int unsigned DEFAULT_DIV = DEF_DIV,
  localparam int unsigned WCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [WCH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pending,
  output logic [NUM_CH-1:0] sq_out
);

  logic [NUM_CH-1:0] wr_hit;

  // One channel per index; an out-of-range wr_ch matches no channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_hit[i] = wr_en && (wr_ch == WCH_W'(i));

    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .en          (ch_en[i]),
      .sync_clr    (sync_clr),
      .wr_hit      (wr_hit[i]),
      .wr_div      (wr_div),
      .tick        (tick[i]),
      .div_pending (div_pending[i]),
      .sq_out      (sq_out[i])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Testbench for multi_tick_gen: directed scenarios plus randomized traffic,
// checked against a period-level reference model.
module tb_multi_tick_gen;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned DEF = 5;

  logic         clk;
  logic         reset;
  logic [N-1:0] ch_en;
  logic         sync_clr;
  logic         wr_en;
  logic [1:0]   wr_ch;
  logic [W-1:0] wr_div;
  logic [N-1:0] tick;
  logic [N-1:0] div_pending;
  logic [N-1:0] sq_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  multi_tick_gen #(
    .NUM_CH      (N),
    .CNT_W       (W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_en       (ch_en),
    .sync_clr    (sync_clr),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_div      (wr_div),
    .tick        (tick),
    .div_pending (div_pending),
    .sq_out      (sq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: elapsed enabled cycles in the current period, the
  // period length in force, and a staged divisor.
  int m_pos  [N];
  int m_div  [N];
  int m_sh   [N];
  bit m_pend [N];
  bit m_tick [N];
  bit m_sq   [N];

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit w;
      int per;
      w   = wr_en && (int'(wr_ch) == i);
      per = (m_div[i] > 1) ? m_div[i] : 1;
      if (reset) begin
        m_pos[i] = 0; m_div[i] = DEF; m_sh[i] = DEF;
        m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
      end else if (sync_clr) begin
        m_pos[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
        if (w) begin m_sh[i] = int'(wr_div); m_pend[i] = 1; end
        if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
      end else if (ch_en[i]) begin
        if (w) begin m_sh[i] = int'(wr_div); m_pend[i] = 1; end
        if (m_pos[i] + 1 >= per) begin
          m_pos[i] = 0; m_tick[i] = 1; m_sq[i] = !m_sq[i];
          if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
        end else begin
          m_pos[i] = m_pos[i] + 1; m_tick[i] = 0;
        end
      end else begin
        m_tick[i] = 0;
        if (m_pend[i]) begin
          if (w) m_sh[i] = int'(wr_div);
          m_div[i] = m_sh[i]; m_pend[i] = 0;
        end else if (w) begin
          m_sh[i] = int'(wr_div); m_pend[i] = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] et, ep, es;
    for (int i = 0; i < N; i++) begin
      et[i] = m_tick[i];
      ep[i] = m_pend[i];
`ifdef MULTI_TICK_GEN_SQUARE_EN
      es[i] = m_sq[i];
`else
      es[i] = 1'b0;
`endif
    end
    check("model_tick", 32'(tick), 32'(et));
    check("model_pend", 32'(div_pending), 32'(ep));
    check("model_sq", 32'(sq_out), 32'(es));
  endtask

  // One clock: edge, model update, sample at negedge, release pulses.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_model();
    wr_en    = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic write(input int ch, input int div);
    wr_en  = 1'b1;
    wr_ch  = 2'(ch);
    wr_div = W'(div);
  endtask

  initial begin
    logic [N-1:0] sq_exp;
    reset = 1'b1; sync_clr = 1'b0; wr_en = 1'b0;
    ch_en = '0; wr_ch = '0; wr_div = '0;
    step();
    step();
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_pend", 32'(div_pending), 32'h0);
    check("rst_sq", 32'(sq_out), 32'h0);

    // Aligned channels at the default divisor.
    reset = 1'b0;
    ch_en = '1;
    for (int s = 1; s <= 15; s++) begin
      step();
      check("align_tick", 32'(tick), (s % 5 == 0) ? 32'hF : 32'h0);
    end

    // Staged divisor applied at the next terminal count.
    do_reset();
    step(); step();
    write(1, 3);
    step();
    check("pend_c3", 32'(div_pending), 32'h2);
    step();
    check("pend_c4", 32'(div_pending), 32'h2);
    check("tick_c4", 32'(tick), 32'h0);
    step();
    check("tick_c5", 32'(tick), 32'hF);
    check("pend_c5", 32'(div_pending), 32'h0);
    for (int s = 6; s <= 11; s++) begin
      step();
      check("ch1_div3", 32'(tick[1]), 32'((s == 8) || (s == 11)));
      check("ch0_div5", 32'(tick[0]), 32'(s == 10));
    end

    // Divisor 0 then 1: tick every enabled cycle.
    do_reset();
    write(2, 0);
    step();
    for (int s = 2; s <= 9; s++) begin
      step();
      check("div0_tick", 32'(tick[2]), 32'(s >= 5));
    end
    write(2, 1);
    for (int s = 10; s <= 13; s++) begin
      step();
      check("div1_tick", 32'(tick[2]), 32'h1);
      check("div1_pend", 32'(div_pending[2]), 32'h0);
    end

    // Disable mid-period, then resume from the held count.
    do_reset();
    step(); step();
    ch_en[0] = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      check("dis_tick", 32'(tick[0]), 32'h0);
    end
    ch_en[0] = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      step();
      check("resume_tick", 32'(tick[0]), 32'(s == 3));
    end

    // sync_clr with a same-cycle write.
    do_reset();
    step(); step(); step();
    write(3, 7);
    sync_clr = 1'b1;
    step();
    check("sync_tick", 32'(tick), 32'h0);
    check("sync_pend", 32'(div_pending), 32'h0);
    for (int s = 1; s <= 7; s++) begin
      step();
      check("sync_after", 32'(tick),
            (s == 5) ? 32'h7 : ((s == 7) ? 32'h8 : 32'h0));
    end

    // Reset mid-period with a pending write discards everything.
    do_reset();
    step(); step();
    write(0, 9);
    step();
    check("pre_rst_pend", 32'(div_pending), 32'h1);
    reset = 1'b1;
    step();
    check("mid_rst_tick", 32'(tick), 32'h0);
    check("mid_rst_pend", 32'(div_pending), 32'h0);
    check("mid_rst_sq", 32'(sq_out), 32'h0);
    reset = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      step();
      check("post_rst_tick", 32'(tick), (s % 5 == 0) ? 32'hF : 32'h0);
`ifdef MULTI_TICK_GEN_SQUARE_EN
      sq_exp = (s >= 5 && s <= 9) ? 4'hF : 4'h0;
`else
      sq_exp = 4'h0;
`endif
      check("post_rst_sq", 32'(sq_out), 32'(sq_exp));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) ch_en[i] = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 3) == 0) write(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
      sync_clr = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
